// File: rtl/tmr_pkg.sv
// rtl/tmr_pkg.sv - scrub FSM state type and per-bit majority-of-three helper
package tmr_pkg;

   typedef enum logic {
      WAIT  = 1'b0,
      SCRUB = 1'b1
   } scrub_state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (b & c) | (a & c);
   endfunction

endpackage

// File: rtl/tmr_vote3.sv
// rtl/tmr_vote3.sv - bitwise 2-of-3 voter with any-mismatch and no-two-equal flags
module tmr_vote3
   import tmr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] voted,
   output logic             mismatch,
   output logic             no_two_equal
);

   always_comb begin
      voted = '0;
      for (int i = 0; i < WIDTH; i++) begin
         voted[i] = maj3(a[i], b[i], c[i]);
      end
   end

   assign mismatch     = (a != b) || (b != c);
   assign no_two_equal = (a != b) && (b != c) && (a != c);

endmodule

// File: rtl/tmr_scrub_reg.sv
// rtl/tmr_scrub_reg.sv - triple-redundant register file with periodic scrub; TMR_FAULT_INJ_EN adds FI_* injection inputs
module tmr_scrub_reg
   import tmr_pkg::*;
#(
   parameter int               WIDTH        = 8,
   parameter int               DEPTH        = 4,
   parameter int               SCRUB_PERIOD = 16,
   parameter int               CNT_W        = 8,
   parameter logic [WIDTH-1:0] RESET_VAL    = '1,
   localparam int              AW           = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             WE,
   input  logic [AW-1:0]    WADDR,
   input  logic [WIDTH-1:0] WD,
   input  logic [AW-1:0]    RADDR,
   output logic [WIDTH-1:0] RD,
   input  logic             SCRUB_EN,
   input  logic             CLR_ERR,
   output logic             ERR_PULSE,
   output logic [CNT_W-1:0] ERR_CNT,
   output logic             MULTI_ERR
`ifdef TMR_FAULT_INJ_EN
   ,
   input  logic             FI_VALID,
   input  logic [1:0]       FI_COPY,
   input  logic [AW-1:0]    FI_ADDR,
   input  logic [WIDTH-1:0] FI_MASK
`endif
);

   localparam int            IW       = $clog2(SCRUB_PERIOD);
   localparam logic [IW-1:0] IVL_LAST = IW'(SCRUB_PERIOD - 1);

   scrub_state_t                state, state_next;
   logic [IW-1:0]               ivl_cnt;
   logic [AW-1:0]               ptr;
   logic [DEPTH-1:0][WIDTH-1:0] copy_a, copy_b, copy_c;
   logic [WIDTH-1:0]            scrub_word;
   logic                        scrub_mismatch, scrub_multi;
   logic                        rd_unused_mismatch, rd_unused_multi;
   logic                        scrub_active, scrub_overwritten, count_evt, multi_evt;

   tmr_vote3 #(.WIDTH(WIDTH)) u_vote_rd (
      .a            (copy_a[RADDR]),
      .b            (copy_b[RADDR]),
      .c            (copy_c[RADDR]),
      .voted        (RD),
      .mismatch     (rd_unused_mismatch),
      .no_two_equal (rd_unused_multi)
   );

   tmr_vote3 #(.WIDTH(WIDTH)) u_vote_scrub (
      .a            (copy_a[ptr]),
      .b            (copy_b[ptr]),
      .c            (copy_c[ptr]),
      .voted        (scrub_word),
      .mismatch     (scrub_mismatch),
      .no_two_equal (scrub_multi)
   );

   // A same-cycle write to the scrubbed word replaces it, so nothing was corrected.
   assign scrub_active      = (state == SCRUB);
   assign scrub_overwritten = WE && (WADDR == ptr);
   assign count_evt         = scrub_active && !scrub_overwritten && scrub_mismatch;
   assign multi_evt         = count_evt && scrub_multi;

   always_comb begin
      state_next = state;
      case (state)
         WAIT:    if (SCRUB_EN && (ivl_cnt == IVL_LAST)) state_next = SCRUB;
         SCRUB:   state_next = WAIT;
         default: state_next = WAIT;
      endcase
   end

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state   <= WAIT;
         ivl_cnt <= '0;
         ptr     <= '0;
      end else begin
         state <= state_next;
         if (state == WAIT) begin
            if (!SCRUB_EN || (ivl_cnt == IVL_LAST)) ivl_cnt <= '0;
            else                                   ivl_cnt <= ivl_cnt + 1'b1;
         end
         if (scrub_active) ptr <= ptr + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         copy_a <= {DEPTH{RESET_VAL}};
         copy_b <= {DEPTH{RESET_VAL}};
         copy_c <= {DEPTH{RESET_VAL}};
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (WE && (WADDR == AW'(i))) begin
               copy_a[i] <= WD;
               copy_b[i] <= WD;
               copy_c[i] <= WD;
            end else if (scrub_active && (ptr == AW'(i))) begin
               copy_a[i] <= scrub_word;
               copy_b[i] <= scrub_word;
               copy_c[i] <= scrub_word;
            end
`ifdef TMR_FAULT_INJ_EN
            else if (FI_VALID && (FI_ADDR == AW'(i))) begin
               case (FI_COPY)
                  2'd0:    copy_a[i] <= copy_a[i] ^ FI_MASK;
                  2'd1:    copy_b[i] <= copy_b[i] ^ FI_MASK;
                  2'd2:    copy_c[i] <= copy_c[i] ^ FI_MASK;
                  default: ;
               endcase
            end
`endif
         end
      end
   end

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         ERR_PULSE <= 1'b0;
         ERR_CNT   <= '0;
         MULTI_ERR <= 1'b0;
      end else begin
         ERR_PULSE <= count_evt;
         if (CLR_ERR) begin
            ERR_CNT   <= '0;
            MULTI_ERR <= 1'b0;
         end else begin
            if (count_evt && (ERR_CNT != {CNT_W{1'b1}})) ERR_CNT <= ERR_CNT + 1'b1;
            if (multi_evt) MULTI_ERR <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tmr_scrub_reg.sv
// tb/tb_tmr_scrub_reg.sv - scoreboard bench for tmr_scrub_reg; uses FI_* ports when TMR_FAULT_INJ_EN is defined
module tb_tmr_scrub_reg;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rn, we, scrub_en, clr_err, err_pulse, multi_err;
   logic [1:0]       waddr, raddr;
   logic [WIDTH-1:0] wd, rd;
   logic [CNT_W-1:0] err_cnt;
   logic             fi_valid;
   logic [1:0]       fi_copy, fi_addr;
   logic [WIDTH-1:0] fi_mask;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int c0;

   typedef struct {
      int               cyc;
      logic [CNT_W-1:0] cnt;
      logic             multi;
   } exp_t;
   exp_t pulse_q[$];

   logic [DEPTH-1:0][WIDTH-1:0] force_v;

   tmr_scrub_reg #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .SCRUB_PERIOD(16), .CNT_W(CNT_W), .RESET_VAL(8'hFF)
   ) dut (
      .CLK(clk), .RN(rn), .WE(we), .WADDR(waddr), .WD(wd), .RADDR(raddr), .RD(rd),
      .SCRUB_EN(scrub_en), .CLR_ERR(clr_err), .ERR_PULSE(err_pulse),
      .ERR_CNT(err_cnt), .MULTI_ERR(multi_err)
`ifdef TMR_FAULT_INJ_EN
      , .FI_VALID(fi_valid), .FI_COPY(fi_copy), .FI_ADDR(fi_addr), .FI_MASK(fi_mask)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic chk_rd(input string nm, input int a, input logic [WIDTH-1:0] exp);
      raddr = 2'(a);
      #1;
      chk(nm, 32'(rd), 32'(exp));
   endtask

   task automatic wr(input int a, input logic [WIDTH-1:0] d);
      we = 1'b1; waddr = 2'(a); wd = d;
      tick(1);
      we = 1'b0;
   endtask

   task automatic expect_pulse(input int c, input int cnt, input logic m);
      exp_t e;
      e.cyc = c; e.cnt = CNT_W'(cnt); e.multi = m;
      pulse_q.push_back(e);
   endtask

   task automatic corrupt(input int cp, input int a, input logic [WIDTH-1:0] m);
`ifdef TMR_FAULT_INJ_EN
      fi_valid = 1'b1; fi_copy = 2'(cp); fi_addr = 2'(a); fi_mask = m;
      tick(1);
      fi_valid = 1'b0;
`else
      case (cp)
         0: begin force_v = dut.copy_a; force_v[a] ^= m; force dut.copy_a = force_v; #1 release dut.copy_a; end
         1: begin force_v = dut.copy_b; force_v[a] ^= m; force dut.copy_b = force_v; #1 release dut.copy_b; end
         default: begin force_v = dut.copy_c; force_v[a] ^= m; force dut.copy_c = force_v; #1 release dut.copy_c; end
      endcase
`endif
   endtask

   // Every ERR_PULSE must match the oldest expected scrub correction.
   always @(negedge clk) begin
      if (err_pulse) begin
         if (pulse_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse: ERR_PULSE=1 at cycle %0d, expected 0", cyc);
         end else begin
            exp_t e;
            e = pulse_q.pop_front();
            chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
            chk("pulse_err_cnt", 32'(err_cnt), 32'(e.cnt));
            chk("pulse_multi_err", 32'(multi_err), 32'(e.multi));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      rn = 1'b0; we = 1'b0; waddr = '0; wd = '0; raddr = '0;
      scrub_en = 1'b0; clr_err = 1'b0;
      fi_valid = 1'b0; fi_copy = '0; fi_addr = '0; fi_mask = '0;
      tick(2);
      for (int a = 0; a < DEPTH; a++) chk_rd("reset_rd", a, 8'hFF);
      chk("reset_err_cnt", 32'(err_cnt), 0);
      chk("reset_multi_err", 32'(multi_err), 0);
      chk("reset_err_pulse", 32'(err_pulse), 0);
      rn = 1'b1;
      tick(1);

      wr(2, 8'h5A);
      chk_rd("wr_rd2", 2, 8'h5A);
      wr(0, 8'h5A);
      wr(1, 8'h3C);
      wr(3, 8'hC3);
      chk_rd("wr_rd0", 0, 8'h5A);
      chk_rd("wr_rd1", 1, 8'h3C);
      chk_rd("wr_rd3", 3, 8'hC3);

      // Round 1: single error, multi error, clean word, multi error cleared on the same edge.
      corrupt(1, 0, 8'h01);
      chk_rd("vote_single", 0, 8'h5A);
      corrupt(0, 1, 8'h01);
      corrupt(1, 1, 8'h02);
      chk_rd("vote_multi1", 1, 8'h3C);
      corrupt(0, 3, 8'h01);
      corrupt(1, 3, 8'h02);
      chk_rd("vote_multi3", 3, 8'hC3);
      scrub_en = 1'b1;
      c0 = cyc;
      expect_pulse(c0 + 17, 1, 1'b0);
      expect_pulse(c0 + 34, 2, 1'b1);
      expect_pulse(c0 + 68, 0, 1'b0);
      wait_cyc(c0 + 67);
      scrub_en = 1'b0;
      clr_err  = 1'b1;
      wait_cyc(c0 + 68);
      clr_err = 1'b0;
      tick(1);
      chk("r1_err_cnt", 32'(err_cnt), 0);
      chk("r1_multi_err", 32'(multi_err), 0);
      chk_rd("r1_rd0", 0, 8'h5A);
      chk_rd("r1_rd1", 1, 8'h3C);
      chk_rd("r1_rd2", 2, 8'h5A);
      chk_rd("r1_rd3", 3, 8'hC3);

      // Round 2: four single-copy errors drive the 2-bit counter into saturation.
      corrupt(1, 0, 8'h01);
      corrupt(0, 1, 8'h04);
      corrupt(2, 2, 8'h10);
      corrupt(1, 3, 8'h80);
      chk_rd("vote_r2_1", 1, 8'h3C);
      scrub_en = 1'b1;
      c0 = cyc;
      expect_pulse(c0 + 17, 1, 1'b0);
      expect_pulse(c0 + 34, 2, 1'b0);
      expect_pulse(c0 + 51, 3, 1'b0);
      expect_pulse(c0 + 68, 3, 1'b0);
      wait_cyc(c0 + 67);
      scrub_en = 1'b0;
      wait_cyc(c0 + 68);
      tick(1);
      chk("r2_err_cnt_sat", 32'(err_cnt), 3);
      chk_rd("r2_rd3", 3, 8'hC3);

      clr_err = 1'b1;
      tick(1);
      clr_err = 1'b0;
      #1;
      chk("clr_err_cnt", 32'(err_cnt), 0);

      // Round 3: write collides with the scrub of a corrupted word.
      corrupt(2, 0, 8'h01);
      corrupt(0, 1, 8'h08);
      scrub_en = 1'b1;
      c0 = cyc;
      expect_pulse(c0 + 34, 1, 1'b0);
      wait_cyc(c0 + 16);
      we = 1'b1; waddr = 2'd0; wd = 8'hA5;
      wait_cyc(c0 + 17);
      we = 1'b0;
      chk_rd("collide_rd0", 0, 8'hA5);
      wait_cyc(c0 + 33);
      scrub_en = 1'b0;
      wait_cyc(c0 + 34);
      tick(1);
      chk_rd("r3_rd1", 1, 8'h3C);
      chk("r3_err_cnt", 32'(err_cnt), 1);

      // Round 4: reset lands inside a scrub cycle of a corrupted word.
      corrupt(1, 2, 8'h01);
      raddr = 2'd2;
      scrub_en = 1'b1;
      c0 = cyc;
      wait_cyc(c0 + 16);
      #2;
      rn = 1'b0;
      #1;
      chk("midreset_rd2", 32'(rd), 32'hFF);
      chk("midreset_err_cnt", 32'(err_cnt), 0);
      chk("midreset_multi_err", 32'(multi_err), 0);
      for (int a = 0; a < DEPTH; a++) chk_rd("midreset_rd", a, 8'hFF);
      tick(1);
      rn = 1'b1;
      c0 = cyc;
      expect_pulse(c0 + 17, 1, 1'b0);
      corrupt(1, 0, 8'h01);
      wait_cyc(c0 + 16);
      scrub_en = 1'b0;
      wait_cyc(c0 + 17);
      tick(1);
      chk_rd("post_reset_rd0", 0, 8'hFF);
      chk("post_reset_err_cnt", 32'(err_cnt), 1);

      tick(2);
      chk("pending_pulses", 32'(pulse_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
